// File: rtl/stream_fifo_pipe_thresh_pkg.sv
// Shared helpers for the stream FIFO: count/pointer width derivation and
// the wrapping pointer increment used by both read and write sides.
package stream_fifo_pipe_thresh_pkg;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Pointers wrap at depth-1 so non-power-of-two depths work.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr >= depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Register-array storage: one synchronous write port, one asynchronous read port.
module stream_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 2
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_W-1:0]     waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [ADDR_W-1:0]     raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_fifo_pipe_thresh.sv
// Valid/ready FIFO with pipe-through on full, flush and almost-full/empty flags.
// Optional same-cycle fall-through on empty: define STREAM_FIFO_FALL_THROUGH_EN.
module stream_fifo_pipe_thresh
  import stream_fifo_pipe_thresh_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = cnt_width(FIFO_DEPTH),
  parameter int AF_THRESH  = 3,
  parameter int AE_THRESH  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_valid_i,
  output logic                  w_ready_o,
  input  logic [DATA_WIDTH-1:0] w_data_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [DATA_WIDTH-1:0] r_data_o,
  input  logic                  flush_i,
  output logic [CNT_WIDTH-1:0]  count_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o
);

  localparam int PTR_W = ptr_width(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] DEPTH_C = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] AF_C    = CNT_WIDTH'(AF_THRESH);
  localparam logic [CNT_WIDTH-1:0] AE_C    = CNT_WIDTH'(AE_THRESH);

  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  empty, full, push, pop, wr_en, rd_adv;

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_C);
  assign w_ready_o = !flush_i && (!full || r_ready_i);

`ifdef STREAM_FIFO_FALL_THROUGH_EN
  logic pass;
  // On empty the incoming beat is presented directly; if taken, it never touches storage.
  assign r_valid_o = !flush_i && (!empty || w_valid_i);
  assign r_data_o  = empty ? w_data_i : mem_rdata;
  assign pass      = push && pop && empty;
  assign wr_en     = push && !pass;
  assign rd_adv    = pop && !pass;
`else
  assign r_valid_o = !flush_i && !empty;
  assign r_data_o  = mem_rdata;
  assign wr_en     = push;
  assign rd_adv    = pop;
`endif

  assign push = w_valid_i && w_ready_o;
  assign pop  = r_valid_o && r_ready_i;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en) wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), FIFO_DEPTH));
    if (rd_adv) rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), FIFO_DEPTH));
    case ({wr_en, rd_adv})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  stream_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (w_data_i),
    .raddr_i (rd_ptr_q),
    .rdata_o (mem_rdata)
  );

  assign count_o        = count_q;
  assign almost_full_o  = (count_q >= AF_C);
  assign almost_empty_o = (count_q <= AE_C);

endmodule
